// File: rtl/piso_pkg.sv
// Shared types and line levels for the framed PISO serializer.
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    GAP
  } state_e;

  localparam logic START_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b0;

endpackage

// File: rtl/piso_frame_serializer.sv
// Framed parallel-in/serial-out stage: start bit, payload, optional even
// parity, one gap bit. Outputs are registered from the next state so every
// output changes on the clock edge that enters the corresponding state.
module piso_frame_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sout,
  output logic              sframe,
  output logic              done
);

  localparam int              CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                par_q, par_d;
  logic                sout_q, sout_d;
  logic                sframe_q, sframe_d;
  logic                done_q, done_d;
  logic                in_ready_q, in_ready_d;
  logic                accept;
  logic [CW-1:0]       bit_idx;

  assign accept = in_valid && in_ready_q;

  // Next-state, counter, holding register and next-state-based output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    par_d    = par_q;
    sout_d   = IDLE_LEVEL;
    sframe_d = 1'b0;
    done_d   = 1'b0;
    bit_idx  = '0;

    // Parity is folded once at capture so the PARITY cycle just replays it.
    if (accept) begin
      data_d = in_data;
      par_d  = ^in_data;
    end

    case (state_q)
      IDLE:    if (accept) state_d = START;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST) state_d = PARITY_EN ? PARITY : GAP;
        else               cnt_d   = cnt_q + 1'b1;
      end
      PARITY:  state_d = GAP;
      GAP:     state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase

    bit_idx = LSB_FIRST ? cnt_d : (LAST - cnt_d);

    case (state_d)
      START: begin
        sout_d   = START_LEVEL;
        sframe_d = 1'b1;
      end
      DATA: begin
        sout_d   = data_d[bit_idx];
        sframe_d = 1'b1;
      end
      PARITY: begin
        sout_d   = par_d;
        sframe_d = 1'b1;
      end
      GAP:     done_d = 1'b1;
      default: ;
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == GAP);
  end

  // State and registered outputs; reset abandons any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      sout_q     <= IDLE_LEVEL;
      sframe_q   <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      par_q      <= par_d;
      sout_q     <= sout_d;
      sframe_q   <= sframe_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign sout     = sout_q;
  assign sframe   = sframe_q;
  assign done     = done_q;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed bench: defaults, LSB-first and no-parity instances share clk/rst.
module tb_piso_frame_serializer;

  logic clk;
  logic rst;

  logic [7:0] a_data, l_data, p_data;
  logic a_valid, l_valid, p_valid;
  logic a_ready, l_ready, p_ready;
  logic a_sout, l_sout, p_sout;
  logic a_sframe, l_sframe, p_sframe;
  logic a_done, l_done, p_done;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;

  piso_frame_serializer #(.DATA_W(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .sout(a_sout), .sframe(a_sframe), .done(a_done));

  piso_frame_serializer #(.DATA_W(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
    .sout(l_sout), .sframe(l_sframe), .done(l_done));

  piso_frame_serializer #(.DATA_W(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_p (
    .clk(clk), .rst(rst), .in_data(p_data), .in_valid(p_valid), .in_ready(p_ready),
    .sout(p_sout), .sframe(p_sframe), .done(p_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake counter for the default instance.
  always @(posedge clk) if (a_valid && a_ready) hs_cnt <= hs_cnt + 1;

  task automatic test_reset();
    rst = 1'b0;
    a_data = '0; l_data = '0; p_data = '0;
    a_valid = 0; l_valid = 0; p_valid = 0;
    @(negedge clk); @(negedge clk);
    tests++; if ({a_sout, a_sframe, a_done, a_ready} !== 4'b0000) begin
      fails++; $display("FAIL reset_a_outs got=%b exp=0000", {a_sout, a_sframe, a_done, a_ready}); end
    tests++; if ({l_sout, l_sframe, l_done, l_ready, p_sout, p_sframe, p_done, p_ready} !== 8'h00) begin
      fails++; $display("FAIL reset_lp_outs got=%b exp=00000000",
        {l_sout, l_sframe, l_done, l_ready, p_sout, p_sframe, p_done, p_ready}); end
    rst = 1'b1;
    #1;
    tests++; if (a_ready !== 1'b0) begin
      fails++; $display("FAIL ready_before_edge got=%b exp=0", a_ready); end
    @(negedge clk);
    tests++; if ({a_ready, l_ready, p_ready} !== 3'b111) begin
      fails++; $display("FAIL ready_first_edge got=%b exp=111", {a_ready, l_ready, p_ready}); end
  endtask

  task automatic test_msb_a5();
    logic [10:0] exp_s;
    exp_s = 11'b1_10100101_0_0;
    a_data = 8'hA5; a_valid = 1;
    @(negedge clk);
    a_valid = 0;
    for (int k = 0; k < 11; k++) begin
      tests++; if (a_sout !== exp_s[10-k]) begin
        fails++; $display("FAIL msb_sout cyc=%0d got=%b exp=%b", k, a_sout, exp_s[10-k]); end
      tests++; if (a_sframe !== (k < 10)) begin
        fails++; $display("FAIL msb_sframe cyc=%0d got=%b exp=%b", k, a_sframe, k < 10); end
      tests++; if (a_done !== (k == 10)) begin
        fails++; $display("FAIL msb_done cyc=%0d got=%b exp=%b", k, a_done, k == 10); end
      tests++; if (a_ready !== (k == 10)) begin
        fails++; $display("FAIL msb_ready cyc=%0d got=%b exp=%b", k, a_ready, k == 10); end
      @(negedge clk);
    end
    tests++; if ({a_sout, a_sframe, a_done, a_ready} !== 4'b0001) begin
      fails++; $display("FAIL msb_idle got=%b exp=0001", {a_sout, a_sframe, a_done, a_ready}); end
  endtask

  task automatic test_lsb_01();
    logic [10:0] exp_s;
    exp_s = 11'b1_10000000_1_0;
    l_data = 8'h01; l_valid = 1;
    @(negedge clk);
    l_valid = 0;
    for (int k = 0; k < 11; k++) begin
      tests++; if (l_sout !== exp_s[10-k]) begin
        fails++; $display("FAIL lsb_sout cyc=%0d got=%b exp=%b", k, l_sout, exp_s[10-k]); end
      tests++; if (l_done !== (k == 10)) begin
        fails++; $display("FAIL lsb_done cyc=%0d got=%b exp=%b", k, l_done, k == 10); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp_s;
    int hs0;
    exp_s = {11'b1_00111100_0_0, 11'b1_11111111_0_0};
    hs0 = hs_cnt;
    a_data = 8'h3C; a_valid = 1;
    @(negedge clk);
    for (int k = 0; k < 22; k++) begin
      tests++; if (a_sout !== exp_s[21-k]) begin
        fails++; $display("FAIL b2b_sout cyc=%0d got=%b exp=%b", k, a_sout, exp_s[21-k]); end
      tests++; if (a_sframe !== ((k % 11) != 10)) begin
        fails++; $display("FAIL b2b_sframe cyc=%0d got=%b exp=%b", k, a_sframe, (k % 11) != 10); end
      tests++; if (a_done !== ((k % 11) == 10)) begin
        fails++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", k, a_done, (k % 11) == 10); end
      if (k == 0) a_data = 8'hFF;
      if (k == 11) a_valid = 0;
      @(negedge clk);
    end
    tests++; if (hs_cnt - hs0 !== 2) begin
      fails++; $display("FAIL b2b_handshakes got=%0d exp=2", hs_cnt - hs0); end
  endtask

  task automatic test_stall_hold();
    logic [21:0] exp_s;
    int hs0;
    exp_s = {11'b1_00010010_0_0, 11'b1_01011010_0_0};
    hs0 = hs_cnt;
    a_data = 8'h12; a_valid = 1;
    @(negedge clk);
    a_valid = 0;
    for (int k = 0; k < 22; k++) begin
      tests++; if (a_sout !== exp_s[21-k]) begin
        fails++; $display("FAIL stall_sout cyc=%0d got=%b exp=%b", k, a_sout, exp_s[21-k]); end
      tests++; if (a_ready !== ((k % 11) == 10)) begin
        fails++; $display("FAIL stall_ready cyc=%0d got=%b exp=%b", k, a_ready, (k % 11) == 10); end
      if (k == 3) begin a_data = 8'h5A; a_valid = 1; end
      if (k == 11) begin a_data = 8'h00; a_valid = 0; end
      @(negedge clk);
    end
    tests++; if (hs_cnt - hs0 !== 2) begin
      fails++; $display("FAIL stall_handshakes got=%0d exp=2", hs_cnt - hs0); end
  endtask

  task automatic test_no_parity();
    logic [9:0] exp_s;
    exp_s = 10'b1_10000000_0;
    p_data = 8'h80; p_valid = 1;
    @(negedge clk);
    p_valid = 0;
    for (int k = 0; k < 10; k++) begin
      tests++; if (p_sout !== exp_s[9-k]) begin
        fails++; $display("FAIL nopar_sout cyc=%0d got=%b exp=%b", k, p_sout, exp_s[9-k]); end
      tests++; if (p_sframe !== (k < 9)) begin
        fails++; $display("FAIL nopar_sframe cyc=%0d got=%b exp=%b", k, p_sframe, k < 9); end
      tests++; if (p_done !== (k == 9)) begin
        fails++; $display("FAIL nopar_done cyc=%0d got=%b exp=%b", k, p_done, k == 9); end
      @(negedge clk);
    end
    tests++; if ({p_sframe, p_done, p_ready} !== 3'b001) begin
      fails++; $display("FAIL nopar_idle got=%b exp=001", {p_sframe, p_done, p_ready}); end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] exp_s;
    exp_s = 11'b1_00001111_0_0;
    a_data = 8'hF0; a_valid = 1;
    @(negedge clk);
    a_valid = 0;
    repeat (4) @(negedge clk);
    // Fourth data bit of 0xF0 (MSB first) is a 1.
    tests++; if ({a_sout, a_sframe} !== 2'b11) begin
      fails++; $display("FAIL pre_reset got=%b exp=11", {a_sout, a_sframe}); end
    #2 rst = 1'b0;
    #1;
    tests++; if ({a_sout, a_sframe, a_done, a_ready} !== 4'b0000) begin
      fails++; $display("FAIL async_clear got=%b exp=0000", {a_sout, a_sframe, a_done, a_ready}); end
    @(negedge clk);
    tests++; if ({a_sout, a_sframe, a_done, a_ready} !== 4'b0000) begin
      fails++; $display("FAIL held_reset got=%b exp=0000", {a_sout, a_sframe, a_done, a_ready}); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({a_sout, a_sframe, a_done, a_ready} !== 4'b0001) begin
      fails++; $display("FAIL post_release got=%b exp=0001", {a_sout, a_sframe, a_done, a_ready}); end
    a_data = 8'h0F; a_valid = 1;
    @(negedge clk);
    a_valid = 0;
    for (int k = 0; k < 11; k++) begin
      tests++; if (a_sout !== exp_s[10-k]) begin
        fails++; $display("FAIL rst_new_sout cyc=%0d got=%b exp=%b", k, a_sout, exp_s[10-k]); end
      tests++; if (a_done !== (k == 10)) begin
        fails++; $display("FAIL rst_new_done cyc=%0d got=%b exp=%b", k, a_done, k == 10); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_msb_a5();
    test_lsb_01();
    test_no_parity();
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_stall_hold();
    repeat (2) @(negedge clk);
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_frame_serializer.md
# piso_frame_serializer

Parallel-in, serial-out framing stage that sits directly upstream of the serial shift-register chain and drives its single-bit serial input. It accepts one DATA_W-bit word per valid/ready handshake and emits a framed bitstream: a start bit, the data bits, an optional even-parity bit, and one idle gap bit. Back-to-back words stream with no extra idle cycles.

## Interface
- DATA_W, 8: payload width in bits, ≥ 2.
- LSB_FIRST, 0: 0 sends the MSB first; 1 sends the LSB first.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  parallel word to send.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the block can accept a word this cycle; registered.
- sout  output  1  serial bitstream to the downstream shift register; registered.
- sframe  output  1  high for every bit of a frame (start, data, parity); low during gap and idle; registered.
- done  output  1  single-cycle pulse during the gap bit of each frame; registered.

## Operation
- Handshake: a word is accepted on a rising edge where in_valid && in_ready. in_data is captured into an internal holding register on that edge. Later changes to in_data do not affect the frame.
- in_valid may be held high with stable data while in_ready is low. The block never drops or duplicates a word.
- FSM states:
  - IDLE: sout=0, sframe=0, in_ready=1. Acceptance moves to START; otherwise stay in IDLE.
  - START: one cycle, sout=1, sframe=1. Next state is DATA, with the bit counter set to 0.
  - DATA: DATA_W cycles, sout = current data bit, sframe=1.
    - With LSB_FIRST=0, counter i selects bit DATA_W-1-i; with LSB_FIRST=1, it selects bit i.
    - After counter DATA_W-1, go to PARITY if PARITY_EN, else GAP.
  - PARITY: one cycle, sout = XOR of all data bits (even parity over the payload), sframe=1. Next state is GAP.
  - GAP: one cycle, sout=0, sframe=0, done=1, in_ready=1. Acceptance this cycle moves to START; otherwise go to IDLE.
- in_ready is 1 only in IDLE and GAP. It is registered, computed from the next state.
- Bit counter width is $clog2(DATA_W). The counter never wraps inside DATA; it is reloaded to 0 on entry to DATA.
- Reset (rst low, asynchronous):
  - Any in-flight word is discarded and the state goes to IDLE.
  - sout=0, sframe=0, done=0, in_ready=0.
  - in_ready rises to 1 on the first rising edge after rst is released.

## Timing
- Accept on edge E: START is visible in the cycle after E, and the first data bit in the cycle after that.
- Frame length F = DATA_W + 2 + PARITY_EN cycles, counting START, data, parity and GAP. Defaults give F = 11.
- Sustained throughput is one word per F cycles when in_valid stays high. The next START immediately follows GAP.
- done rises exactly F-1 cycles after START first appears.
- sout, sframe and done change only on rising clock edges, apart from the asynchronous reset clear.

## Structure
- Shared package piso_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, GAP);
  - START_LEVEL = 1'b1 and IDLE_LEVEL = 1'b0.
- Single module with no sub-module. Parity is computed once at acceptance and stored alongside the held word.

## Test plan
1. Defaults, send 0xA5 with a single handshake. Required sout from START: 1, then 1,0,1,0,0,1,0,1, then parity 0, then gap 0. sframe is high for 10 cycles and done pulses once in the gap cycle.
2. LSB_FIRST=1, send 0x01. Required sout: 1, then 1,0,0,0,0,0,0,0, then parity 1, then 0.
3. Back-to-back with in_valid held high, send 0x3C then 0xFF. The second START follows the first GAP immediately, 11 cycles apart. Exactly two handshakes occur, and the 0xFF frame has parity 0.
4. Stall and hold: assert in_valid=1 with 0x5A mid-frame. in_ready stays low until GAP, and the word is accepted exactly once. Changing in_data after acceptance does not alter the transmitted bits.
5. PARITY_EN=0, send 0x80. The frame is 10 cycles: 1, then 1,0,0,0,0,0,0,0, then gap 0. No parity bit appears.
6. Assert rst low during the 4th data bit. sout, sframe, done and in_ready drop to 0 immediately. After release, in_ready rises on the first edge, and a new 0x0F frame transmits correctly with no remnant of the aborted word.
